// File: rtl/store_rmw_ctrl_if.sv
// store_rmw_ctrl_if: request handshake and data-memory bus of the store sequencer
interface store_rmw_ctrl_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] b_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    output start, store_type, addr, b_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, err
  );
  modport slave (
    input  start, store_type, addr, b_data, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, err
  );
endinterface

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: multicycle store sequencer; SW writes directly, SH/SB read-modify-write
module store_rmw_ctrl #(
  parameter int RD_WAIT = 1
) (
  input logic             clk,
  input logic             reset,
  store_rmw_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_MERGE, S_WRITE, S_FIN} state_t;
  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [1:0]  typ, typ_n;
  logic [31:0] b_q, b_n, mdr, mdr_n, addr_n, wdata_n, mask;
  logic        wr_n, done_n, err_n, busy_n;
  // mem_addr doubles as the latched store address; outputs are registered,
  // so the write pulse appears the cycle after the WRITE state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    typ_n   = typ;
    b_n     = b_q;
    mdr_n   = mdr;
    addr_n  = bus.mem_addr;
    wdata_n = bus.mem_wdata;
    wr_n    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    mask    = typ == 2'b01 ? 32'hFFFF_0000 : 32'hFFFF_FF00;
    case (state)
      S_IDLE: if (bus.start && !bus.busy) begin
        typ_n   = bus.store_type;
        b_n     = bus.b_data;
        state_n = bus.store_type == 2'b11 ? S_FIN : bus.store_type == 2'b00 ? S_WRITE : S_RD_REQ;
        addr_n  = bus.store_type == 2'b11 ? bus.mem_addr : bus.addr;
        wdata_n = bus.store_type == 2'b00 ? bus.b_data : bus.mem_wdata;
      end
      S_RD_REQ: begin
        cnt_n   = 3'(RD_WAIT - 1);
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cnt_n   = cnt == 3'd0 ? cnt : cnt - 3'd1;
        mdr_n   = cnt == 3'd0 ? bus.mem_rdata : mdr;
        state_n = cnt == 3'd0 ? S_MERGE : S_RD_WAIT;
      end
      S_MERGE: begin
        wdata_n = (mdr & mask) | (b_q & ~mask);
        state_n = S_WRITE;
      end
      S_WRITE: begin
        wr_n    = 1'b1;
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      S_FIN: begin
        done_n  = 1'b1;
        err_n   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = state_n != S_IDLE || done_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      typ           <= '0;
      b_q           <= '0;
      mdr           <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wr    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      typ           <= typ_n;
      b_q           <= b_n;
      mdr           <= mdr_n;
      bus.mem_addr  <= addr_n;
      bus.mem_wdata <= wdata_n;
      bus.mem_wr    <= wr_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
      bus.err       <= err_n;
    end
  end
endmodule
